fetch_unit: RTL



---
 rtl/fetch_unit_if.sv | 11 +
 rtl/fetch_unit.sv | 108 ++++++++++
 2 files changed

// File: rtl/fetch_unit_if.sv
// Byte-wide instruction memory bus between the fetch unit (master) and the
// variable-latency instruction memory (slave).
interface fetch_unit_if;
  logic [7:0] MEM_ADDR;
  logic       MEM_RD;
  logic [7:0] MEM_DATA;
  logic       MEM_VALID;

  modport master (output MEM_ADDR, output MEM_RD, input MEM_DATA, input MEM_VALID);
  modport slave  (input MEM_ADDR, input MEM_RD, output MEM_DATA, output MEM_VALID);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: assembles a big-endian 16-bit word from byte memory,
// pulses EN_L once per delivered instruction, caches the last fetch for self-loops.
module fetch_unit #(
  parameter int unsigned TIMEOUT  = 15,
  parameter logic [15:0] NOP_WORD = 16'h0000
) (
  input  logic         CLK,
  input  logic         RESET_L,
  input  logic [7:0]   PC,
  output logic [15:0]  Iin,
  output logic         EN_L,
  output logic         FAULT,
  fetch_unit_if.master mem_bus
);

  typedef enum logic [1:0] {CHECK, FETCH_HI, FETCH_LO, ISSUE} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_t      state_q;
  logic [7:0]  hi_q;
  logic [7:0]  tmo_q;
  logic [7:0]  tag_q;
  logic [7:0]  addr_q;
  logic        cvalid_q;
  logic        rd_q;
  logic        en_l_q;
  logic        fault_q;
  logic [15:0] iin_q;

  logic        accept;
  logic        expire;
  logic        hit;
  logic [7:0]  pc_inc;

  assign accept = rd_q & mem_bus.MEM_VALID;
  assign expire = (tmo_q == TMO_LAST);
  // Iin only changes on a good capture or a timeout, and a timeout drops
  // cache_valid, so Iin itself is the cached word whenever the tag matches.
  assign hit    = cvalid_q && (PC == tag_q);
  assign pc_inc = PC + 8'd1;

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      state_q  <= CHECK;
      hi_q     <= '0;
      tmo_q    <= '0;
      tag_q    <= '0;
      addr_q   <= '0;
      cvalid_q <= 1'b0;
      rd_q     <= 1'b0;
      en_l_q   <= 1'b1;
      fault_q  <= 1'b0;
      iin_q    <= NOP_WORD;
    end else begin
      case (state_q)
        CHECK: begin
          if (hit) begin
            en_l_q  <= 1'b0;
            state_q <= ISSUE;
          end else begin
            addr_q  <= PC;
            rd_q    <= 1'b1;
            tmo_q   <= '0;
            state_q <= FETCH_HI;
          end
        end
        FETCH_HI, FETCH_LO: begin
          if (accept && (state_q == FETCH_HI)) begin
            hi_q    <= mem_bus.MEM_DATA;
            tmo_q   <= '0;
            addr_q  <= pc_inc;
            state_q <= FETCH_LO;
          end else if (accept) begin
            iin_q    <= {hi_q, mem_bus.MEM_DATA};
            tag_q    <= PC;
            cvalid_q <= 1'b1;
            rd_q     <= 1'b0;
            en_l_q   <= 1'b0;
            state_q  <= ISSUE;
          end else if (expire) begin
            iin_q    <= NOP_WORD;
            fault_q  <= 1'b1;
            cvalid_q <= 1'b0;
            tmo_q    <= '0;
            rd_q     <= 1'b0;
            en_l_q   <= 1'b0;
            state_q  <= ISSUE;
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
        end
        ISSUE: begin
          en_l_q  <= 1'b1;
          state_q <= CHECK;
        end
        default: state_q <= CHECK;
      endcase
    end
  end

  assign Iin              = iin_q;
  assign EN_L             = en_l_q;
  assign FAULT            = fault_q;
  assign mem_bus.MEM_ADDR = addr_q;
  assign mem_bus.MEM_RD   = rd_q;

endmodule
